// File: rtl/reg_file_sb_pkg.sv
// Shared register-file constants used by the register file, decode and the hazard unit.
package reg_file_sb_pkg;
   localparam int RF_DATA_W = 32;
   localparam int RF_NREGS  = 32;
   localparam int RF_ADDR_W = 5;

   // Architectural zero register: reads as 0, writes and issues to it are discarded.
   localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;
endpackage : reg_file_sb_pkg

// File: rtl/reg_file_sb_bypass.sv
// One read port: selects zero, the in-flight writeback value, or the stored value,
// and reports whether the operand is valid this cycle.
module rf_bypass_mux
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] stored_data,
   input  logic              stored_busy,
   output logic [DATA_W-1:0] data,
   output logic              rdy
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      data = stored_data;
      rdy  = ~stored_busy;
      if (rd_addr == REG_ZERO) begin
         data = '0;
         rdy  = 1'b1;
      end else if (wr_en && (wr_addr == rd_addr)) begin
         // The writeback completes the producer, so the operand is valid regardless of busy.
         data = wr_data;
         rdy  = 1'b1;
      end
   end

endmodule : rf_bypass_mux

// File: rtl/reg_file_sb.sv
// MIPS register file with two combinational read ports, one write port and a
// per-register busy scoreboard used by decode to stall on RAW hazards.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int NREGS  = RF_NREGS,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              flush,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_rdy_a,
   output logic              rd_rdy_b
);

   // Register 0 has no storage; entries start at index 1.
   logic [DATA_W-1:0] regs [1:NREGS-1];
   logic [NREGS-1:1]  busy;

   logic [DATA_W-1:0] stored_a, stored_b;
   logic              busy_a, busy_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         // NOTE: the storage array is reset explicitly because reads after reset must return 0.
         for (int i = 1; i < NREGS; i++) regs[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every read in this block on pre-edge state.
         if (wr_en && (wr_addr != REG_ZERO)) regs[wr_addr] <= wr_data;

         if (flush) begin
            busy <= '0;
         end else begin
            if (wr_en && (wr_addr != REG_ZERO)) busy[wr_addr] <= 1'b0;
            // Placed last so a same-address issue overrides the clear: the new producer wins.
            if (iss_en && (iss_addr != REG_ZERO)) busy[iss_addr] <= 1'b1;
         end
      end
   end

   always_comb begin
      stored_a = '0;
      stored_b = '0;
      busy_a   = 1'b0;
      busy_b   = 1'b0;
      if (rd_addr_a != REG_ZERO) begin
         stored_a = regs[rd_addr_a];
         busy_a   = busy[rd_addr_a];
      end
      if (rd_addr_b != REG_ZERO) begin
         stored_b = regs[rd_addr_b];
         busy_b   = busy[rd_addr_b];
      end
   end

   rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
      .rd_addr     (rd_addr_a),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .stored_data (stored_a),
      .stored_busy (busy_a),
      .data        (rd_data_a),
      .rdy         (rd_rdy_a)
   );

   rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
      .rd_addr     (rd_addr_b),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .stored_data (stored_b),
      .stored_busy (busy_b),
      .data        (rd_data_b),
      .rdy         (rd_rdy_b)
   );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, r0, RAW lifecycle, issue/writeback race, flush, dual port.
module tb_reg_file_sb;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic        flush;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rd_data_a, rd_data_b;
   logic        rd_rdy_a, rd_rdy_b;

   int checks = 0;
   int errors = 0;

   reg_file_sb dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr),
      .flush     (flush),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .rd_rdy_a  (rd_rdy_a),
      .rd_rdy_b  (rd_rdy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr_inputs();
      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
   endtask

   // Advance one edge, then return 1 time unit later with inputs cleared.
   task automatic cycle();
      @(posedge clk);
      #1;
      clr_inputs();
   endtask

   task automatic test_reset();
      rd_addr_a = 5'd1; rd_addr_b = 5'd31; #1;
      checks++; if (rd_data_a !== 32'h0 || rd_rdy_a !== 1'b1) begin
         errors++; $display("FAIL reset_state_r1 data=%h rdy=%b exp data=00000000 rdy=1", rd_data_a, rd_rdy_a); end
      checks++; if (rd_data_b !== 32'h0 || rd_rdy_b !== 1'b1) begin
         errors++; $display("FAIL reset_state_r31 data=%h rdy=%b exp data=00000000 rdy=1", rd_data_b, rd_rdy_b); end
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; cycle();
      iss_en = 1'b1; iss_addr = 5'd7; cycle();
      rd_addr_a = 5'd5; rd_addr_b = 5'd7; #1;
      checks++; if (rd_data_a !== 32'hDEADBEEF || rd_rdy_b !== 1'b0) begin
         errors++; $display("FAIL pre_reset r5=%h r7_rdy=%b exp r5=deadbeef r7_rdy=0", rd_data_a, rd_rdy_b); end
      // rst must also override a write and an issue in the same cycle.
      rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11111111;
      iss_en = 1'b1; iss_addr = 5'd5; cycle();
      #1;
      checks++; if (rd_data_a !== 32'h0 || rd_rdy_a !== 1'b1) begin
         errors++; $display("FAIL reset_r5 data=%h rdy=%b exp data=00000000 rdy=1", rd_data_a, rd_rdy_a); end
      checks++; if (rd_rdy_b !== 1'b1 || rd_data_b !== 32'h0) begin
         errors++; $display("FAIL reset_r7 data=%h rdy=%b exp data=00000000 rdy=1", rd_data_b, rd_rdy_b); end
   endtask

   task automatic test_reg_zero();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      iss_en = 1'b1; iss_addr = 5'd0;
      rd_addr_a = 5'd0; rd_addr_b = 5'd0; #1;
      checks++; if (rd_data_a !== 32'h0 || rd_rdy_a !== 1'b1 || rd_data_b !== 32'h0 || rd_rdy_b !== 1'b1) begin
         errors++; $display("FAIL r0_same_cycle a=%h/%b b=%h/%b exp 00000000/1 both", rd_data_a, rd_rdy_a, rd_data_b, rd_rdy_b); end
      cycle(); #1;
      checks++; if (rd_data_a !== 32'h0 || rd_rdy_a !== 1'b1 || rd_data_b !== 32'h0 || rd_rdy_b !== 1'b1) begin
         errors++; $display("FAIL r0_next_cycle a=%h/%b b=%h/%b exp 00000000/1 both", rd_data_a, rd_rdy_a, rd_data_b, rd_rdy_b); end
   endtask

   task automatic test_raw();
      iss_en = 1'b1; iss_addr = 5'd3; cycle();
      rd_addr_a = 5'd3; rd_addr_b = 5'd0; #1;
      checks++; if (rd_rdy_a !== 1'b0) begin
         errors++; $display("FAIL raw_busy rdy_a=%b exp 0", rd_rdy_a); end
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55AA; #1;
      checks++; if (rd_data_a !== 32'h55AA || rd_rdy_a !== 1'b1) begin
         errors++; $display("FAIL raw_bypass data=%h rdy=%b exp 000055aa/1", rd_data_a, rd_rdy_a); end
      cycle(); #1;
      checks++; if (rd_data_a !== 32'h55AA || rd_rdy_a !== 1'b1) begin
         errors++; $display("FAIL raw_stored data=%h rdy=%b exp 000055aa/1", rd_data_a, rd_rdy_a); end
   endtask

   task automatic test_same_cycle();
      iss_en = 1'b1; iss_addr = 5'd9; cycle();
      rd_addr_a = 5'd9; rd_addr_b = 5'd9; #1;
      checks++; if (rd_rdy_a !== 1'b0) begin
         errors++; $display("FAIL race_busy rdy=%b exp 0", rd_rdy_a); end
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
      iss_en = 1'b1; iss_addr = 5'd9; cycle(); #1;
      checks++; if (rd_data_a !== 32'h99 || rd_rdy_a !== 1'b0) begin
         errors++; $display("FAIL race_set_wins data=%h rdy=%b exp 00000099/0", rd_data_a, rd_rdy_a); end
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA9; cycle(); #1;
      checks++; if (rd_data_a !== 32'hA9 || rd_rdy_a !== 1'b1) begin
         errors++; $display("FAIL race_release data=%h rdy=%b exp 000000a9/1", rd_data_a, rd_rdy_a); end
      // Writeback to one register must not disturb an issue to another in the same edge.
      iss_en = 1'b1; iss_addr = 5'd20; wr_en = 1'b1; wr_addr = 5'd21; wr_data = 32'h21; cycle();
      rd_addr_a = 5'd20; rd_addr_b = 5'd21; #1;
      checks++; if (rd_rdy_a !== 1'b0 || rd_rdy_b !== 1'b1 || rd_data_b !== 32'h21) begin
         errors++; $display("FAIL split_iss_wr r20_rdy=%b r21=%h/%b exp 0 and 00000021/1", rd_rdy_a, rd_data_b, rd_rdy_b); end
   endtask

   task automatic test_flush();
      iss_en = 1'b1; iss_addr = 5'd1; cycle();
      iss_en = 1'b1; iss_addr = 5'd2; cycle();
      iss_en = 1'b1; iss_addr = 5'd4; cycle();
      rd_addr_a = 5'd1; rd_addr_b = 5'd4; #1;
      checks++; if (rd_rdy_a !== 1'b0 || rd_rdy_b !== 1'b0) begin
         errors++; $display("FAIL pre_flush r1_rdy=%b r4_rdy=%b exp 0 0", rd_rdy_a, rd_rdy_b); end
      flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd7; cycle();
      rd_addr_a = 5'd1; rd_addr_b = 5'd2; #1;
      checks++; if (rd_rdy_a !== 1'b1 || rd_rdy_b !== 1'b1 || rd_data_b !== 32'd7) begin
         errors++; $display("FAIL flush_r1_r2 r1_rdy=%b r2=%h/%b exp 1 and 00000007/1", rd_rdy_a, rd_data_b, rd_rdy_b); end
      rd_addr_a = 5'd4; rd_addr_b = 5'd6; #1;
      checks++; if (rd_rdy_a !== 1'b1 || rd_rdy_b !== 1'b1) begin
         errors++; $display("FAIL flush_r4_r6 r4_rdy=%b r6_rdy=%b exp 1 1", rd_rdy_a, rd_rdy_b); end
   endtask

   task automatic test_dual_port();
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE0001; cycle();
      rd_addr_a = 5'd10; rd_addr_b = 5'd10; #1;
      checks++; if (rd_data_a !== 32'hCAFE0001 || rd_data_b !== 32'hCAFE0001 || rd_rdy_a !== 1'b1 || rd_rdy_b !== 1'b1) begin
         errors++; $display("FAIL dual_ready a=%h/%b b=%h/%b exp cafe0001/1 both", rd_data_a, rd_rdy_a, rd_data_b, rd_rdy_b); end
      iss_en = 1'b1; iss_addr = 5'd10; cycle(); #1;
      checks++; if (rd_data_a !== 32'hCAFE0001 || rd_data_b !== 32'hCAFE0001 || rd_rdy_a !== 1'b0 || rd_rdy_b !== 1'b0) begin
         errors++; $display("FAIL dual_busy a=%h/%b b=%h/%b exp cafe0001/0 both", rd_data_a, rd_rdy_a, rd_data_b, rd_rdy_b); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4];
      vals[0] = 32'h0000_1111; vals[1] = 32'h2222_0000;
      vals[2] = 32'hF0F0_F0F0; vals[3] = 32'h0F0F_0F0F;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_addr = 5'(11 + i); wr_data = vals[i];
         rd_addr_a = 5'(11 + i); rd_addr_b = 5'(10 + i); #1;
         checks++; if (rd_data_a !== vals[i] || rd_rdy_a !== 1'b1) begin
            errors++; $display("FAIL b2b_bypass_%0d data=%h rdy=%b exp %h/1", i, rd_data_a, rd_rdy_a, vals[i]); end
         if (i > 0) begin
            checks++; if (rd_data_b !== vals[i-1]) begin
               errors++; $display("FAIL b2b_stored_%0d data=%h exp %h", i, rd_data_b, vals[i-1]); end
         end
         cycle();
      end
   endtask

   initial begin
      clr_inputs();
      rd_addr_a = '0; rd_addr_b = '0;
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      test_reset();
      test_reg_zero();
      test_raw();
      test_same_cycle();
      test_flush();
      test_dual_port();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
# reg_file_sb

32-entry MIPS general-purpose register file with two combinational read ports, one write port, and an integrated per-register busy scoreboard. It sits between decode/issue and writeback. Writeback writes the file; decode reads operands and readiness flags. The decode stage uses the ready flags to stall on RAW hazards, so the hazard unit needs no separate pending-destination tracking.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W == NREGS

Ports:
- clk  in  1  single system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk
- wr_en  in  1  writeback valid
- wr_addr  in  ADDR_W  writeback destination register
- wr_data  in  DATA_W  writeback value
- iss_en  in  1  an instruction with a destination register is issuing this cycle
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- flush  in  1  pipeline flush; clears every busy bit
- rd_addr_a, rd_addr_b  in  ADDR_W  source operand indices
- rd_data_a, rd_data_b  out  DATA_W  operand values (combinational)
- rd_rdy_a, rd_rdy_b  out  1  operand is valid this cycle (combinational)

## Operation
- Storage: regs[1..NREGS-1] hold DATA_W bits each; busy[1..NREGS-1] hold 1 bit each. Index 0 is not stored.
- Read, per port:
  - rd_addr==0 gives data 0 and rdy 1.
  - If wr_en && wr_addr==rd_addr && rd_addr!=0, the port bypasses: data=wr_data, rdy=1, regardless of busy.
  - Otherwise data=regs[rd_addr] and rdy=~busy[rd_addr].
- Write: on the clock edge with wr_en && wr_addr!=0, regs[wr_addr] takes wr_data. Writes to register 0 are dropped.
- Busy update at the clock edge, evaluated in priority order (first match wins):
  1. rst: all busy bits cleared.
  2. flush: all busy bits cleared. iss_en in the same cycle is ignored. wr_en still writes data.
  3. iss_en && iss_addr!=0: busy[iss_addr] is set. This applies even if wr_en targets the same address in the same cycle (set wins, because the new producer supersedes the old one).
  4. wr_en && wr_addr!=0 && wr_addr!=iss_addr (or !iss_en): busy[wr_addr] is cleared.
- Busy is a single bit, not a count. The issue logic guarantees at most one in-flight producer per register. A second issue to an already-busy register leaves it busy, and the first writeback clears it.
- Both read ports are fully independent and may use the same address.

## Timing
- Reset: with rst high at an edge, all regs become 0 and all busy bits become 0 at that edge. After that edge every rd_data reads 0 and every rd_rdy reads 1. rst overrides wr_en, iss_en and flush.
- Read latency: 0 cycles (combinational from rd_addr, wr_*, and state).
- Write-to-read: same cycle via bypass; from the next cycle via storage.
- Issue-to-not-ready: 1 cycle. rd_rdy for iss_addr drops in the cycle after iss_en.
- Writeback-to-ready: 0 cycles via bypass. busy clears at the same edge.
- Reset asserted mid-operation discards all pending busy state and data. Writebacks that arrive afterwards still write and still clear busy (a no-op on an already-clear bit).

## Structure
- Shared package: DATA_W/ADDR_W/NREGS constants and the REG_ZERO index constant, shared with decode and the hazard unit.
- One natural sub-module: rf_bypass_mux (one per read port). It takes rd_addr, wr_en, wr_addr, wr_data, the stored value and the busy bit, and produces data and rdy. This covers the zero/bypass/storage selection.
- Storage and the scoreboard stay in the top module as flat arrays; no memory macro is used.

## Test plan
- Reset: write 0xDEADBEEF to r5, issue r7, then assert rst for one cycle. Required: r5 reads 0, and rd_rdy for r7 is 1.
- Register zero: wr_en with r0=0x1234 and iss_en r0, then read r0 on both ports. Required: data 0, rdy 1 on both, and no busy bit set.
- RAW lifecycle:
  - Issue r3; next cycle read r3 → rdy_a=0.
  - In the writeback cycle, wr r3=0x55AA on the same cycle as the read → rd_data_a=0x55AA with rdy=1.
  - The following cycle, again reads 0x55AA with rdy=1.
- Simultaneous issue and writeback to r9: r9 busy, then wr r9 and iss r9 in the same edge. Required: the data is written, and rdy for r9 is 0 next cycle. A later wr r9 sets rdy back to 1.
- Flush: issue r1, r2, r4, then assert flush together with iss r6 and wr r2=7. Required: next cycle all of r1/r2/r4/r6 are ready, and r2 reads 7.
- Dual-port same address: both ports read r10=0xCAFE0001 while busy[r10]=0. Required: identical data on both ports and both rdy=1. Repeat with r10 busy → both rdy=0.
